// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - glyph constants, segment bit indices and glyph lookup
package seven_seg_pkg;

    localparam int BIT_A  = 0;
    localparam int BIT_B  = 1;
    localparam int BIT_C  = 2;
    localparam int BIT_D  = 3;
    localparam int BIT_E  = 4;
    localparam int BIT_F  = 5;
    localparam int BIT_G  = 6;
    localparam int BIT_DP = 7;

    // Active-high words, bit order {dp, g, f, e, d, c, b, a}
    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_A     = 8'h77;
    localparam logic [7:0] SEG_B     = 8'h7C;
    localparam logic [7:0] SEG_C     = 8'h39;
    localparam logic [7:0] SEG_D     = 8'h5E;
    localparam logic [7:0] SEG_E     = 8'h79;
    localparam logic [7:0] SEG_F     = 8'h71;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    function automatic logic [7:0] glyph(input logic [3:0] code, input logic hex_mode);
        logic [7:0] word;
        case (code)
            4'd0:    word = SEG_0;
            4'd1:    word = SEG_1;
            4'd2:    word = SEG_2;
            4'd3:    word = SEG_3;
            4'd4:    word = SEG_4;
            4'd5:    word = SEG_5;
            4'd6:    word = SEG_6;
            4'd7:    word = SEG_7;
            4'd8:    word = SEG_8;
            4'd9:    word = SEG_9;
            4'd10:   word = hex_mode ? SEG_A : SEG_BLANK;
            4'd11:   word = hex_mode ? SEG_B : SEG_BLANK;
            4'd12:   word = hex_mode ? SEG_C : SEG_BLANK;
            4'd13:   word = hex_mode ? SEG_D : SEG_BLANK;
            4'd14:   word = hex_mode ? SEG_E : SEG_BLANK;
            4'd15:   word = hex_mode ? SEG_F : SEG_BLANK;
            default: word = SEG_BLANK;
        endcase
        // The decimal point is never lit by the decoder
        word[BIT_DP] = 1'b0;
        return word;
    endfunction

endpackage

// File: rtl/seg_glyph_lut.sv
// rtl/seg_glyph_lut.sv - combinational digit code to active-high segment word
module seg_glyph_lut
    import seven_seg_pkg::*;
#(
    parameter bit HEX_MODE = 1'b0
) (
    input  logic [3:0] bcd,
    output logic [7:0] glyph_word
);

    assign glyph_word = glyph(bcd, HEX_MODE);

endmodule

// File: rtl/seven_segment_display.sv
// rtl/seven_segment_display.sv - registered BCD/hex to seven-segment decoder
module seven_segment_display
    import seven_seg_pkg::*;
#(
    parameter bit COMMON_ANODE = 1'b0,
    parameter bit HEX_MODE     = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] bcd,
    output logic [7:0] segment
);

    localparam logic [7:0] OFF_WORD = COMMON_ANODE ? ~SEG_BLANK : SEG_BLANK;

    logic [7:0] glyph_word;
    logic [7:0] drive_word;

    seg_glyph_lut #(
        .HEX_MODE (HEX_MODE)
    ) u_lut (
        .bcd        (bcd),
        .glyph_word (glyph_word)
    );

    assign drive_word = COMMON_ANODE ? ~glyph_word : glyph_word;

    // Pins are driven straight from this flop so no decode glitches reach the display
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            segment <= OFF_WORD;
        end else begin
            segment <= drive_word;
        end
    end

endmodule

// File: tb/tb_seven_segment_display.sv
// tb/tb_seven_segment_display.sv - directed vector bench over all four parameter combinations
module tb_seven_segment_display;

    typedef struct {
        logic [3:0] code;
        logic [7:0] ah_dec;
        logic [7:0] ca_dec;
        logic [7:0] ah_hex;
        logic [7:0] ca_hex;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] bcd;
    logic [7:0] seg_ah_dec;
    logic [7:0] seg_ca_dec;
    logic [7:0] seg_ah_hex;
    logic [7:0] seg_ca_hex;

    int applied;
    int miscompares;

    vec_t vecs [20];

    seven_segment_display #(.COMMON_ANODE(1'b0), .HEX_MODE(1'b0)) dut_ah_dec (
        .clk(clk), .rst_n(rst_n), .bcd(bcd), .segment(seg_ah_dec));
    seven_segment_display #(.COMMON_ANODE(1'b1), .HEX_MODE(1'b0)) dut_ca_dec (
        .clk(clk), .rst_n(rst_n), .bcd(bcd), .segment(seg_ca_dec));
    seven_segment_display #(.COMMON_ANODE(1'b0), .HEX_MODE(1'b1)) dut_ah_hex (
        .clk(clk), .rst_n(rst_n), .bcd(bcd), .segment(seg_ah_hex));
    seven_segment_display #(.COMMON_ANODE(1'b1), .HEX_MODE(1'b1)) dut_ca_hex (
        .clk(clk), .rst_n(rst_n), .bcd(bcd), .segment(seg_ca_hex));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h, required %02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check4(input string name, input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3);
        check({name, "/ah_dec"}, seg_ah_dec, e0);
        check({name, "/ca_dec"}, seg_ca_dec, e1);
        check({name, "/ah_hex"}, seg_ah_hex, e2);
        check({name, "/ca_hex"}, seg_ca_hex, e3);
    endtask

    initial begin
        vecs[0]  = '{4'd0,  8'h3F, 8'hC0, 8'h3F, 8'hC0};
        vecs[1]  = '{4'd1,  8'h06, 8'hF9, 8'h06, 8'hF9};
        vecs[2]  = '{4'd2,  8'h5B, 8'hA4, 8'h5B, 8'hA4};
        vecs[3]  = '{4'd3,  8'h4F, 8'hB0, 8'h4F, 8'hB0};
        vecs[4]  = '{4'd4,  8'h66, 8'h99, 8'h66, 8'h99};
        vecs[5]  = '{4'd5,  8'h6D, 8'h92, 8'h6D, 8'h92};
        vecs[6]  = '{4'd6,  8'h7D, 8'h82, 8'h7D, 8'h82};
        vecs[7]  = '{4'd7,  8'h07, 8'hF8, 8'h07, 8'hF8};
        vecs[8]  = '{4'd8,  8'h7F, 8'h80, 8'h7F, 8'h80};
        vecs[9]  = '{4'd9,  8'h6F, 8'h90, 8'h6F, 8'h90};
        vecs[10] = '{4'd10, 8'h00, 8'hFF, 8'h77, 8'h88};
        vecs[11] = '{4'd11, 8'h00, 8'hFF, 8'h7C, 8'h83};
        vecs[12] = '{4'd12, 8'h00, 8'hFF, 8'h39, 8'hC6};
        vecs[13] = '{4'd13, 8'h00, 8'hFF, 8'h5E, 8'hA1};
        vecs[14] = '{4'd14, 8'h00, 8'hFF, 8'h79, 8'h86};
        vecs[15] = '{4'd15, 8'h00, 8'hFF, 8'h71, 8'h8E};
        vecs[16] = '{4'd1,  8'h06, 8'hF9, 8'h06, 8'hF9};
        vecs[17] = '{4'd8,  8'h7F, 8'h80, 8'h7F, 8'h80};
        vecs[18] = '{4'd1,  8'h06, 8'hF9, 8'h06, 8'hF9};
        vecs[19] = '{4'd8,  8'h7F, 8'h80, 8'h7F, 8'h80};

        applied     = 0;
        miscompares = 0;
        rst_n       = 1'b1;
        bcd         = 4'd8;

        // Asynchronous reset before any clock edge
        #2 rst_n = 1'b0;
        #1 check4("reset_async", 8'h00, 8'hFF, 8'h00, 8'hFF);
        @(negedge clk) rst_n = 1'b1;
        check4("reset_hold_until_edge", 8'h00, 8'hFF, 8'h00, 8'hFF);
        @(posedge clk); #1;
        check4("reset_release_8", 8'h7F, 8'h80, 8'h7F, 8'h80);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk) bcd = vecs[i].code;
            @(posedge clk); #1;
            check4($sformatf("vec%0d_code%0d", i, vecs[i].code),
                   vecs[i].ah_dec, vecs[i].ca_dec, vecs[i].ah_hex, vecs[i].ca_hex);
        end

        // One-cycle lag and no mid-cycle response
        @(negedge clk) bcd = 4'd1;
        #1 check4("lag_before_edge", 8'h7F, 8'h80, 8'h7F, 8'h80);
        @(posedge clk); #1;
        check4("lag_after_edge_1", 8'h06, 8'hF9, 8'h06, 8'hF9);
        #2 bcd = 4'd8;
        #1 check4("midcycle_toggle_8", 8'h06, 8'hF9, 8'h06, 8'hF9);
        #1 bcd = 4'd1;
        @(negedge clk);
        check4("midcycle_toggle_back", 8'h06, 8'hF9, 8'h06, 8'hF9);
        @(posedge clk); #1;
        check4("unchanged_bcd_hold", 8'h06, 8'hF9, 8'h06, 8'hF9);

        // Mid-stream reset discards the displayed digit
        @(negedge clk) bcd = 4'd5;
        @(posedge clk); #1;
        check4("pre_reset_5", 8'h6D, 8'h92, 8'h6D, 8'h92);
        #1 rst_n = 1'b0;
        #1 check4("midstream_reset", 8'h00, 8'hFF, 8'h00, 8'hFF);
        @(negedge clk) rst_n = 1'b1;
        #1 check4("midstream_reset_released", 8'h00, 8'hFF, 8'h00, 8'hFF);
        @(posedge clk); #1;
        check4("post_reset_5", 8'h6D, 8'h92, 8'h6D, 8'h92);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
